// File: rtl/regfile_pair_if.sv
// Bus bundle for regfile_pair: write port, two read ports and the register-pair pointer port.
interface regfile_pair_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned STEP_W = 4
);
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_sel;
  logic [DATA_W-1:0]     wr_data;
  logic [ADDR_W-1:0]     rd_a_sel;
  logic [ADDR_W-1:0]     rd_b_sel;
  logic [DATA_W-1:0]     rd_a;
  logic [DATA_W-1:0]     rd_b;
  logic [1:0]            pair_op;
  logic [STEP_W-1:0]     step;
  logic [2*DATA_W-1:0]   pair_out;
  logic [DATA_W-1:0]     pair_hi;
  logic                  pair_wrap;
  logic                  pair_conflict;

  modport master (
    output wr_en, wr_sel, wr_data, rd_a_sel, rd_b_sel, pair_op, step,
    input  rd_a, rd_b, pair_out, pair_hi, pair_wrap, pair_conflict
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, rd_a_sel, rd_b_sel, pair_op, step,
    output rd_a, rd_b, pair_out, pair_hi, pair_wrap, pair_conflict
  );
endinterface

// File: rtl/regfile_pair.sv
// Register file with two async read ports, one sync write port and an even/odd
// register-pair pointer port supporting +1, -1 and signed-step updates.
module regfile_pair #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned STEP_W = 4,
  parameter int unsigned BYPASS = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  regfile_pair_if.slave  bus
);
  localparam int unsigned NREG = 1 << ADDR_W;
  localparam int unsigned PW   = 2 * DATA_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              wrap_q, wrap_d;
  logic              conflict_q, conflict_d;

  logic [ADDR_W-1:0] lo_sel, hi_sel;
  logic              pair_valid;
  logic [PW-1:0]     pair_cur;
  logic [PW-1:0]     delta;
  logic [PW:0]       sum;
  logic              op_active, conflict, apply, wrapped;

  assign lo_sel     = bus.rd_b_sel & ~ADDR_W'(1);
  assign hi_sel     = lo_sel | ADDR_W'(1);
  assign pair_valid = ~bus.rd_b_sel[0];
  assign pair_cur   = pair_valid ? {regs_q[hi_sel], regs_q[lo_sel]} : '0;

  always_comb begin
    delta = '0;
    case (bus.pair_op)
      2'b01:   delta = PW'(1);
      2'b10:   delta = '1;
      2'b11:   delta = PW'($signed(bus.step));
      default: delta = '0;
    endcase
  end

  // Negative deltas are added in two's complement: a borrow is the absence of carry-out.
  assign sum       = {1'b0, pair_cur} + {1'b0, delta};
  assign wrapped   = delta[PW-1] ? ~sum[PW] : sum[PW];
  assign op_active = (bus.pair_op != 2'b00) && pair_valid;
  assign conflict  = op_active && bus.wr_en &&
                     ((bus.wr_sel == lo_sel) || (bus.wr_sel == hi_sel));
  assign apply     = op_active && !conflict;

  always_comb begin
    regs_d = regs_q;
    if (apply) begin
      regs_d[lo_sel] = sum[DATA_W-1:0];
      regs_d[hi_sel] = sum[PW-1:DATA_W];
    end
    if (bus.wr_en) regs_d[bus.wr_sel] = bus.wr_data;
    wrap_d     = apply && wrapped;
    conflict_d = conflict;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      wrap_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      wrap_q     <= wrap_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    bus.rd_a = regs_q[bus.rd_a_sel];
    bus.rd_b = regs_q[bus.rd_b_sel];
    if (BYPASS != 0 && bus.wr_en) begin
      if (bus.wr_sel == bus.rd_a_sel) bus.rd_a = bus.wr_data;
      if (bus.wr_sel == bus.rd_b_sel) bus.rd_b = bus.wr_data;
    end
  end

  assign bus.pair_out      = pair_cur;
  assign bus.pair_hi       = pair_cur[PW-1:DATA_W];
  assign bus.pair_wrap     = wrap_q;
  assign bus.pair_conflict = conflict_q;
endmodule

// File: tb/tb_regfile_pair.sv
// Directed bench for regfile_pair; a BYPASS=0 copy shares the stimulus to check the non-forwarding read path.
module tb_regfile_pair;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_pair_if #(.DATA_W(8), .ADDR_W(4), .STEP_W(4)) bus ();
  regfile_pair_if #(.DATA_W(8), .ADDR_W(4), .STEP_W(4)) nb ();

  regfile_pair #(.DATA_W(8), .ADDR_W(4), .STEP_W(4), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  regfile_pair #(.DATA_W(8), .ADDR_W(4), .STEP_W(4), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .bus(nb.slave));

  assign nb.wr_en    = bus.wr_en;
  assign nb.wr_sel   = bus.wr_sel;
  assign nb.wr_data  = bus.wr_data;
  assign nb.rd_a_sel = bus.rd_a_sel;
  assign nb.rd_b_sel = bus.rd_b_sel;
  assign nb.pair_op  = bus.pair_op;
  assign nb.step     = bus.step;

  typedef enum int { K_RDA, K_RDB, K_POUT, K_PHI, K_WRAP, K_CONF, K_NB_RDA } kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [15:0] observe(kind_t k);
    case (k)
      K_RDA:    return {8'h00, bus.rd_a};
      K_RDB:    return {8'h00, bus.rd_b};
      K_POUT:   return bus.pair_out;
      K_PHI:    return {8'h00, bus.pair_hi};
      K_WRAP:   return {15'h0, bus.pair_wrap};
      K_CONF:   return {15'h0, bus.pair_conflict};
      K_NB_RDA: return {8'h00, nb.rd_a};
      default:  return 16'hxxxx;
    endcase
  endfunction

  task automatic expect_v(string tag, kind_t k, logic [15:0] v);
    exp_t e;
    e.tag = tag; e.kind = k; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [15:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [3:0] sel, logic [7:0] data);
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_sel = '0; bus.wr_data = '0;
    bus.rd_a_sel = '0; bus.rd_b_sel = '0; bus.pair_op = 2'b00; bus.step = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset: fill with A5, then async reset between edges
    for (int i = 0; i < 16; i++) wr(4'(i), 8'hA5);
    bus.rd_a_sel = 4'd3; bus.rd_b_sel = 4'd12;
    expect_v("fill_rda", K_RDA, 16'h00A5);
    expect_v("fill_pair", K_POUT, 16'hA5A5);
    drain();
    rst_n = 1'b0;
    expect_v("rst_rda", K_RDA, 16'h0000);
    expect_v("rst_rdb", K_RDB, 16'h0000);
    expect_v("rst_pair", K_POUT, 16'h0000);
    expect_v("rst_wrap", K_WRAP, 16'h0);
    expect_v("rst_conf", K_CONF, 16'h0);
    drain();
    rst_n = 1'b1;
    tick();
    bus.rd_a_sel = 4'd15;
    expect_v("rst_r15", K_RDA, 16'h0000);
    drain();

    // Increment wrap FFFF+1
    wr(4'd2, 8'hFF); wr(4'd3, 8'hFF);
    bus.rd_b_sel = 4'd2; bus.pair_op = 2'b01;
    expect_v("inc_pre", K_POUT, 16'hFFFF);
    expect_v("inc_pre_hi", K_PHI, 16'h00FF);
    drain();
    tick(); bus.pair_op = 2'b00;
    expect_v("inc_post", K_POUT, 16'h0000);
    expect_v("inc_wrap", K_WRAP, 16'h1);
    drain();
    tick();
    expect_v("inc_wrap_drop", K_WRAP, 16'h0);
    drain();

    // Decrement wrap 0000-1
    bus.pair_op = 2'b10;
    tick(); bus.pair_op = 2'b00;
    expect_v("dec_post", K_POUT, 16'hFFFF);
    expect_v("dec_wrap", K_WRAP, 16'h1);
    drain();

    // Signed step -3
    wr(4'd4, 8'h10); wr(4'd5, 8'h00);
    bus.rd_b_sel = 4'd4; bus.step = 4'hD; bus.pair_op = 2'b11;
    tick(); bus.pair_op = 2'b00;
    expect_v("step_post", K_POUT, 16'h000D);
    expect_v("step_nowrap", K_WRAP, 16'h0);
    drain();
    wr(4'd4, 8'h01);
    bus.pair_op = 2'b11;
    tick(); bus.pair_op = 2'b00;
    expect_v("step_neg", K_POUT, 16'hFFFE);
    expect_v("step_wrap", K_WRAP, 16'h1);
    drain();

    // Conflict: write into the pair wins, pair update dropped
    wr(4'd6, 8'h34); wr(4'd7, 8'h12);
    bus.rd_b_sel = 4'd6; bus.pair_op = 2'b01;
    bus.wr_en = 1'b1; bus.wr_sel = 4'd7; bus.wr_data = 8'h99;
    tick(); bus.pair_op = 2'b00; bus.wr_en = 1'b0;
    expect_v("conf_pair", K_POUT, 16'h9934);
    expect_v("conf_flag", K_CONF, 16'h1);
    expect_v("conf_nowrap", K_WRAP, 16'h0);
    drain();
    wr(4'd7, 8'h12);
    expect_v("conf_drop", K_CONF, 16'h0);
    drain();
    bus.pair_op = 2'b01;
    bus.wr_en = 1'b1; bus.wr_sel = 4'd9; bus.wr_data = 8'h5A;
    tick(); bus.wr_en = 1'b0;
    bus.rd_a_sel = 4'd9;
    expect_v("other_pair", K_POUT, 16'h1235);
    expect_v("other_r9", K_RDA, 16'h005A);
    expect_v("other_noconf", K_CONF, 16'h0);
    drain();
    // Chained increments, op held two more cycles
    tick(); tick(); bus.pair_op = 2'b00;
    expect_v("chain", K_POUT, 16'h1237);
    drain();

    // Odd select: no output, no update, no flags
    bus.rd_b_sel = 4'd7; bus.pair_op = 2'b10;
    expect_v("odd_pout", K_POUT, 16'h0000);
    expect_v("odd_phi", K_PHI, 16'h0000);
    drain();
    tick(); bus.pair_op = 2'b00;
    bus.rd_a_sel = 4'd6;
    expect_v("odd_r7", K_RDB, 16'h0012);
    expect_v("odd_r6", K_RDA, 16'h0037);
    expect_v("odd_wrap", K_WRAP, 16'h0);
    expect_v("odd_conf", K_CONF, 16'h0);
    drain();

    // Forwarding vs. no forwarding; pair_hi never forwarded
    bus.rd_a_sel = 4'd5; bus.rd_b_sel = 4'd4;
    bus.wr_en = 1'b1; bus.wr_sel = 4'd5; bus.wr_data = 8'h3C;
    expect_v("fwd_rda", K_RDA, 16'h003C);
    expect_v("nofwd_rda", K_NB_RDA, 16'h00FF);
    expect_v("fwd_phi", K_PHI, 16'h00FF);
    drain();
    tick(); bus.wr_en = 1'b0;
    expect_v("nofwd_after", K_NB_RDA, 16'h003C);
    expect_v("fwd_phi_after", K_PHI, 16'h003C);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_pair.md
# regfile_pair

Parametrised register file for the tinySoC CPU core, succeeding the fixed 16×8 file. It provides two asynchronous read ports, one synchronous write port, and a register-pair pointer port. The pointer port supports increment, decrement and signed-step add on an even/odd register pair, with write-forwarding and registered wrap and conflict status. It sits between the decoder/ALU and the memory-address path, the same place as the current file.

## Interface
Parameters:
- DATA_W, default 8: register width in bits.
- ADDR_W, default 4: select width; the file holds 2**ADDR_W registers (must be ≥1).
- STEP_W, default 4: width of the signed step for the add-step op (≤ 2*DATA_W).
- BYPASS, default 1: 1 forwards same-cycle write data to rd_a/rd_b; 0 gives no forwarding.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_sel  in  ADDR_W  write register index.
- wr_data  in  DATA_W  write data.
- rd_a_sel  in  ADDR_W  port A select.
- rd_b_sel  in  ADDR_W  port B select; also the pair select.
- rd_a  out  DATA_W  register[rd_a_sel], combinational.
- rd_b  out  DATA_W  register[rd_b_sel], combinational.
- pair_op  in  2  pair operation: 00 none, 01 +1, 10 −1, 11 +sign-extended step.
- step  in  STEP_W  signed step for op 11.
- pair_out  out  2*DATA_W  {reg[hi], reg[lo]} of the selected pair, combinational, pre-update value.
- pair_hi  out  DATA_W  reg[hi] of the selected pair.
- pair_wrap  out  1  registered; high for the cycle after a pair update that wrapped.
- pair_conflict  out  1  registered; high for the cycle after a pair op was suppressed by a write.

## Operation
- Pair selection: lo = {rd_b_sel[ADDR_W-1:1],0}, hi = lo+1.
  - If rd_b_sel[0]=1, the pair is invalid: pair_out=0, pair_hi=0, and any pair_op is ignored (no update, no flags).
- Write: if wr_en, reg[wr_sel] ← wr_data at the clock edge.
- Pair update: with pair_op≠00, a valid pair, and no conflict, {hi,lo} ← pair_out + delta, computed modulo 2**(2*DATA_W).
  - delta is +1, −1 (all ones), or step sign-extended to 2*DATA_W.
- Conflict: wr_en and wr_sel ∈ {lo,hi} together with a valid pair_op.
  - The write takes effect and the pair update is dropped entirely (neither half changes).
  - pair_conflict ← 1.
- Writes to other registers in the same cycle as a pair update both take effect.
- Wrap: pair_wrap ← 1 when an applied update carries out of bit 2*DATA_W−1 (increment/positive step) or borrows (decrement/negative step). Examples: FFFF+1, 0000−1.
- Forwarding (BYPASS=1): if wr_en and wr_sel equals rd_a_sel (resp. rd_b_sel), rd_a (resp. rd_b) = wr_data.
  - pair_out and pair_hi are never forwarded.
  - With BYPASS=0, reads return stored values only.
- Reset: all registers ← 0; pair_wrap, pair_conflict ← 0. Reset is effective immediately on rst_n low, independent of clk.

## Timing
- Read latency 0 (combinational from selects and state).
- Write and pair-update latency 1: new values are visible on the reads after the rising edge.
- pair_wrap and pair_conflict are one-cycle pulses asserted the cycle after the causing edge. Back-to-back events keep them high.
- Consecutive pair ops on the same pair each cycle chain correctly, since each uses the registered result of the previous one.
- Reset mid-sequence discards all pending effects; the first edge after rst_n rises behaves as a fresh start. No update occurs on an edge while rst_n=0.
- After reset, all outputs are 0 (rd_a = rd_b = 0 unless forwarding a concurrent write with BYPASS=1).

## Test plan
- Reset: load all registers with 0xA5, pulse rst_n low between edges -> all reads 0x00 immediately; flags 0.
- Increment wrap: r3:r2=0xFFFF, rd_b_sel=2, pair_op=01 -> next cycle pair_out=0x0000, pair_wrap=1 for one cycle, then 0.
- Signed step: r5:r4=0x0010, STEP_W=4, step=4'hD (−3), op=11 -> 0x000D, no wrap. Repeat from 0x0001 -> 0xFFFE, wrap=1.
- Conflict: r7:r6=0x1234, op=01 with wr_en, wr_sel=7, wr_data=0x99 -> 0x9934 and pair_conflict=1. Same op with wr_sel=9 -> 0x1235 and r9 written.
- Odd select: rd_b_sel=3, op=10 -> pair_out=0, no register changes, no flags.
- Forwarding: BYPASS=1, wr_en, wr_sel=rd_a_sel=5, wr_data=0x3C -> rd_a=0x3C the same cycle. With BYPASS=0 -> old value, then 0x3C after the edge.
